// File: rtl/mod_inv_scheduler.sv
// Round-robin scheduler sharing one multi-cycle modular-inversion engine among NUM_REQ requesters.
// Optional engine watchdog enabled by defining MOD_INV_TIMEOUT_EN.
module mod_inv_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_operand,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     eng_start,
    output logic [WIDTH-1:0]         eng_operand,
    input  logic                     eng_done,
    input  logic [WIDTH-1:0]         eng_result,
    output logic                     eng_abort,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_err,
    output logic                     busy
);

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("mod_inv_scheduler: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [WIDTH-1:0]   gnt_op;
    logic               found;
    int                 idx;

    // First valid requester at or after the rr pointer, wrapping around.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = ID_W'(idx);
            end
        end
    end

    assign gnt_op = req_operand[int'(gnt_id)*WIDTH +: WIDTH];

`ifdef MOD_INV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            abort;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef MOD_INV_TIMEOUT_EN
        wdog_d  = wdog_q;
        abort   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    op_d = gnt_op;
                    id_d = gnt_id;
                    rr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
                    if (gnt_op == '0) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef MOD_INV_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (eng_done) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef MOD_INV_TIMEOUT_EN
                // This is the TIMEOUT-th WAIT cycle with no result: abort and report.
                else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wdog_d  = wdog_q + WD_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef MOD_INV_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef MOD_INV_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

`ifdef MOD_INV_TIMEOUT_EN
    assign eng_abort = abort;
`else
    assign eng_abort = 1'b0;
`endif

    assign req_ready   = (state_q == S_IDLE) ? grant : '0;
    assign eng_start   = (state_q == S_ISSUE);
    assign eng_operand = (state_q == S_ISSUE || state_q == S_WAIT) ? op_q : '0;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_err     = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
